// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: PC/instruction widths, fetch FSM
// states and the buffered instruction entry.
package riscv_pkg;

  localparam int PC_W    = 8;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;
  localparam int FIFO_D  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } inst_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with synchronous push/pop/flush.
// The head reads zero while the buffer is empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 40,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != '0);
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: issues one imem read at a time at pc_cur,
// steers the PC register via pc_next and buffers returned words for decode.
module if_fetch
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc_cur,
  output logic [PC_W-1:0]   pc_next,
  output logic              imem_req_valid,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  output logic [1:0]        fetch_state
);

  localparam int CW = $clog2(FIFO_D) + 1;

  fetch_state_t    state;
  logic [PC_W-1:0] req_pc;
  logic            drop;
  logic [CW-1:0]   fifo_count;
  logic            credit_ok;
  logic            req_fire;
  logic            push;
  logic            pop;
  inst_entry       push_entry;
  inst_entry       head_entry;

  // Handshakes: a transfer happens on a cycle where valid && ready are both high.
  // Once raised, valid/addr hold until ready; only a redirect withdraws the
  // request, and only when memory is not accepting it in that same cycle.
  assign credit_ok      = (fifo_count < CW'(FIFO_D));
  assign imem_req_valid = (state == REQ) && credit_ok &&
                          (!redirect_valid || imem_req_ready);
  assign imem_req_addr  = pc_cur;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = (state == WAIT) && imem_rsp_valid && !drop && !redirect_valid;
  assign pop  = inst_ready && inst_valid;

  always_comb begin
    pc_next = pc_cur;
    if (redirect_valid) pc_next = redirect_pc;
    else if (req_fire)  pc_next = pc_cur + PC_W'(PC_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_pc <= '0;
      drop   <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (req_fire) begin
            req_pc <= pc_cur;
            drop   <= redirect_valid;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            drop  <= 1'b0;
            state <= REQ;
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push_entry = '{pc: req_pc, inst: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH ($bits(inst_entry))
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_valid (inst_valid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

  assign inst_data   = head_entry.inst;
  assign inst_pc     = head_entry.pc;
  assign fetch_state = state;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: plays the PC register and instruction memory, checks a
// hand-derived vector table, a mid-fetch async reset and random traffic.
module tb_if_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pc_cur = '0;
  logic [7:0]  pc_next;
  logic        imem_req_valid;
  logic [7:0]  imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic        inst_ready = 1'b0;
  logic [1:0]  fetch_state;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_cur         (pc_cur),
    .pc_next        (pc_next),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_state    (fetch_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffered {pc, inst} entries, at most one outstanding read.
  logic [39:0] exp_q[$];
  logic        m_active, m_out, m_drop;
  logic [7:0]  m_opc, m_pc;
  logic        mem_busy;
  int          mem_cnt;
  logic [7:0]  mem_addr;
  int          c_dly;
  logic        exp_rv, fire;
  logic [7:0]  exp_pcn;

  typedef struct {
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       irdy;
    int         dly;
    logic       rv;
    logic [7:0] addr;
    logic [7:0] pcn;
    logic       iv;
    logic [7:0] ipc;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [31:0] mem_data(input logic [7:0] a);
    if (a == 8'h00) return 32'h0000_0013;
    return {a, 8'h5A, ~a, 8'h13};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    m_active = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_opc = '0; m_pc = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    inst_ready = 1'b0; pc_cur = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle's inputs just after a falling edge and check predictions.
  task automatic apply(input logic rdy, input logic redir, input logic [7:0] rpc,
                       input logic irdy, input int dly);
    c_dly          = dly;
    imem_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = irdy;
    pc_cur         = m_pc;
    imem_rsp_valid = mem_busy && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_data(mem_addr) : 32'($urandom);
    #1;
    exp_rv  = m_active && !m_out && (exp_q.size() < 2) && !(redir && !rdy);
    fire    = exp_rv && rdy;
    exp_pcn = redir ? rpc : (fire ? m_pc + 8'd4 : m_pc);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, m_pc);
    check("pc_next", pc_next, exp_pcn);
    check("inst_valid", inst_valid, exp_q.size() != 0);
    check("inst_head", {inst_pc, inst_data}, (exp_q.size() != 0) ? exp_q[0] : 40'h0);
  endtask

  // Advance the model across the rising edge, then wait for the next falling edge.
  task automatic finish_cycle();
    logic rsp;
    rsp = imem_rsp_valid;
    if (inst_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (rsp && m_out) begin
      if (!m_drop && !redirect_valid) exp_q.push_back({m_opc, mem_data(m_opc)});
      m_out  = 1'b0;
      m_drop = 1'b0;
    end
    if (redirect_valid) begin
      exp_q.delete();
      if (m_out) m_drop = 1'b1;
    end
    if (fire) begin
      m_out  = 1'b1;
      m_opc  = m_pc;
      m_drop = redirect_valid;
    end
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (fire) begin
      mem_busy = 1'b1;
      mem_cnt  = c_dly;
      mem_addr = m_pc;
    end
    m_pc     = exp_pcn;
    m_active = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    //         rdy   redir rpc    irdy dly  rv    addr   pc_next iv    inst_pc
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h00, 8'h04, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h04, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h04, 8'h08, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h08, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h08, 1'b1, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h08, 1'b1, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 8'h08, 1'b1, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h08, 8'h0C, 1'b1, 8'h04};
    tbl[9]  = '{1'b1, 1'b1, 8'h40, 1'b0, 0, 1'b0, 8'h00, 8'h40, 1'b1, 8'h04};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h40, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h40, 8'h44, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h44, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h44, 8'h48, 1'b1, 8'h40};
    tbl[14] = '{1'b1, 1'b1, 8'h80, 1'b0, 0, 1'b0, 8'h00, 8'h80, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h80, 8'h80, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 1'b1, 8'hFC, 1'b0, 0, 1'b0, 8'h00, 8'hFC, 1'b0, 8'h00};
    tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'hFC, 8'h00, 1'b0, 8'h00};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h00, 8'h04, 1'b1, 8'hFC};
    tbl[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 8'h04, 1'b1, 8'hFC};
    tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h04, 8'h04, 1'b1, 8'h00};

    reset_model();
    #2;
    check("reset req_valid", imem_req_valid, 1'b0);
    check("reset inst_valid", inst_valid, 1'b0);
    check("reset inst_head", {inst_pc, inst_data}, 40'h0);
    check("reset state", fetch_state, IDLE);
    do_reset();

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].rdy, tbl[i].redir, tbl[i].rpc, tbl[i].irdy, tbl[i].dly);
      check($sformatf("vec%0d req_valid", i), imem_req_valid, tbl[i].rv);
      if (tbl[i].rv) check($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].addr);
      check($sformatf("vec%0d pc_next", i), pc_next, tbl[i].pcn);
      check($sformatf("vec%0d inst_valid", i), inst_valid, tbl[i].iv);
      check($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].ipc);
      check($sformatf("vec%0d inst_data", i), inst_data,
            tbl[i].iv ? mem_data(tbl[i].ipc) : 32'h0);
      finish_cycle();
    end

    // Async reset while a read is outstanding and the buffer holds an entry.
    apply(1'b1, 1'b0, 8'h00, 1'b0, 2);
    check("pre-reset fire", imem_req_valid, 1'b1);
    finish_cycle();
    apply(1'b1, 1'b0, 8'h00, 1'b0, 0);
    check("pre-reset inst_valid", inst_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async req_valid", imem_req_valid, 1'b0);
    check("async inst_valid", inst_valid, 1'b0);
    check("async state", fetch_state, IDLE);
    do_reset();
    apply(1'b1, 1'b0, 8'h00, 1'b0, 0);
    check("refetch idle", imem_req_valid, 1'b0);
    finish_cycle();
    apply(1'b1, 1'b0, 8'h00, 1'b0, 0);
    check("refetch valid", imem_req_valid, 1'b1);
    check("refetch addr", imem_req_addr, 8'h00);
    check("refetch pc_next", pc_next, 8'h04);
    finish_cycle();

    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
            8'($urandom_range(0, 63) * 4), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)));
      finish_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
